// File: rtl/pcie_wr_pkg.sv
// Shared definitions for the PCIe write-segment feeder: header field
// positions, FSM state encoding and beat-size helpers.
package pcie_wr_pkg;

    // Segment header layout (144 bits, upper bits are zero)
    localparam int HDR_W    = 144;
    localparam int ADDR_LSB = 0;
    localparam int ADDR_MSB = 63;
    localparam int LEN_LSB  = 64;
    localparam int LEN_MSB  = 76;
    localparam int TAG_LSB  = 77;
    localparam int TAG_MSB  = 84;
    localparam int LAST_BIT = 85;

    // Default data beat width in bits
    localparam int DEF_DWIDTH = 256;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        WAIT = 3'd2,
        DATA = 3'd3,
        HEAD = 3'd4
    } state_e;

    // Bytes carried by one data beat
    function automatic int beat_bytes(input int dwidth);
        return dwidth / 8;
    endfunction

    // Ceiling log2, used for the beat-byte shift and boundary offset width
    function automatic int log2_ceil(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/pcie_wr_seg.sv
// Splits byte-addressed write commands into BUFUNIT-bounded segments,
// streams each segment's beats into the FIFO data side, then commits one
// header per segment.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends combinationally on the same port's valid.
// iPcie_ready is a segment-level credit, consulted only before a segment's
// data starts.
module pcie_wr_seg
    import pcie_wr_pkg::*;
#(
    parameter int BUFUNIT = 4096,
    parameter int DWIDTH  = DEF_DWIDTH,
    parameter int LEN_W   = 16
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic              iCmd_valid,
    output logic              oCmd_ready,
    input  logic [63:0]       iCmd_addr,
    input  logic [LEN_W-1:0]  iCmd_len,
    input  logic [7:0]        iCmd_tag,
    input  logic              iData_valid,
    output logic              oData_ready,
    input  logic [DWIDTH-1:0] iData,
    input  logic              iData_last,
    input  logic              iPcie_ready,
    output logic [HDR_W-1:0]  oPcie_headin,
    output logic              oPcie_Hwrreq,
    output logic [DWIDTH-1:0] oPcie_datain,
    output logic              oPcie_wrreq,
    output logic              oBusy,
    output logic              oErr,
    output logic [31:0]       oSeg_cnt,
    output logic [2:0]        oDbg_state
);

    localparam int BB      = beat_bytes(DWIDTH);
    localparam int LOG2_BB = log2_ceil(BB);
    localparam int BU_LOG2 = log2_ceil(BUFUNIT);
    localparam int CW      = LEN_W + 1;
    localparam int LEN_FW  = LEN_MSB - LEN_LSB + 1;

    localparam logic [CW-1:0] BU_C  = CW'(BUFUNIT);
    localparam logic [CW-1:0] BB_M1 = CW'(BB - 1);

    state_e          state_q, state_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic [63:0]     addr_q, addr_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic [CW-1:0]   seg_len_q, seg_len_d;
    logic [CW-1:0]   seg_beats_q, seg_beats_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [7:0]      tag_q, tag_d;
    logic            err_q, err_d;
    logic [31:0]     seg_cnt_q, seg_cnt_d;

    logic [CW-1:0]   room_c;
    logic [CW-1:0]   seg_len_c;
    logic            beat_fire;
    logic            last_beat;
    logic            final_seg;
    logic [HDR_W-1:0] hdr_c;

    // State and datapath registers; everything clears on reset
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            addr_q      <= '0;
            rem_q       <= '0;
            seg_len_q   <= '0;
            seg_beats_q <= '0;
            beat_cnt_q  <= '0;
            tag_q       <= '0;
            err_q       <= 1'b0;
            seg_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            seg_len_q   <= seg_len_d;
            seg_beats_q <= seg_beats_d;
            beat_cnt_q  <= beat_cnt_d;
            tag_q       <= tag_d;
            err_q       <= err_d;
            seg_cnt_q   <= seg_cnt_d;
        end
    end

    // Next-state logic: command intake, segment sizing, beat counting, commit
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        seg_len_d   = seg_len_q;
        seg_beats_d = seg_beats_q;
        beat_cnt_d  = beat_cnt_q;
        tag_d       = tag_q;
        err_d       = err_q;
        seg_cnt_d   = seg_cnt_q;

        room_c    = BU_C - CW'(addr_q[BU_LOG2-1:0]);
        seg_len_c = (rem_q < room_c) ? rem_q : room_c;
        beat_fire = (state_q == DATA) && iData_valid;
        last_beat = ((beat_cnt_q + CW'(1)) == seg_beats_q);
        final_seg = (rem_q == seg_len_q);

        case (state_q)
            IDLE: begin
                if (cmd_ready_q && iCmd_valid) begin
                    addr_d = iCmd_addr;
                    rem_d  = {1'b0, iCmd_len};
                    tag_d  = iCmd_tag;
                    if ((iCmd_addr[LOG2_BB-1:0] != '0) || (iCmd_len[1:0] != 2'b00)) begin
                        err_d = 1'b1;
                    end else if (iCmd_len != '0) begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                seg_len_d   = seg_len_c;
                seg_beats_d = (seg_len_c + BB_M1) >> LOG2_BB;
                beat_cnt_d  = '0;
                state_d     = WAIT;
            end
            WAIT: begin
                if (iPcie_ready) state_d = DATA;
            end
            DATA: begin
                if (beat_fire) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    // Last flag must sit on the final beat of the final segment only
                    if (iData_last != (last_beat && final_seg)) err_d = 1'b1;
                    if (last_beat) state_d = HEAD;
                end
            end
            HEAD: begin
                addr_d    = addr_q + 64'(seg_len_q);
                rem_d     = rem_q - seg_len_q;
                seg_cnt_d = seg_cnt_q + 32'd1;
                state_d   = final_seg ? IDLE : CALC;
            end
            default: state_d = IDLE;
        endcase

        // Registered so it stays low through reset and rises one cycle after
        cmd_ready_d = (state_d == IDLE);
    end

    // Header image, driven only during the commit cycle
    always_comb begin
        hdr_c = '0;
        if (state_q == HEAD) begin
            hdr_c[ADDR_MSB:ADDR_LSB] = addr_q;
            hdr_c[LEN_MSB:LEN_LSB]   = seg_len_q[LEN_FW-1:0];
            hdr_c[TAG_MSB:TAG_LSB]   = tag_q;
            hdr_c[LAST_BIT]          = final_seg;
        end
    end

    assign oCmd_ready   = cmd_ready_q;
    assign oData_ready  = (state_q == DATA);
    assign oPcie_wrreq  = beat_fire;
    assign oPcie_datain = beat_fire ? iData : '0;
    assign oPcie_Hwrreq = (state_q == HEAD);
    assign oPcie_headin = hdr_c;
    assign oBusy        = (state_q != IDLE);
    assign oErr         = err_q;
    assign oSeg_cnt     = seg_cnt_q;
    assign oDbg_state   = state_q;

endmodule

// File: tb/tb_pcie_wr_seg.sv
// Bench for pcie_wr_seg: one instance with 4096-byte segments and one with
// 256-byte segments, directed cases followed by randomized commands, all
// checked against a segment-splitting reference model.
module tb_pcie_wr_seg;
    import pcie_wr_pkg::*;

    localparam int DW = 256;
    localparam int BB = DW / 8;
    localparam int BU0 = 4096;
    localparam int BU1 = 256;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- DUT signals (index 0: BU0, index 1: BU1) ----------------
    logic          cmd_valid  [2];
    logic          cmd_ready  [2];
    logic [63:0]   cmd_addr   [2];
    logic [15:0]   cmd_len    [2];
    logic [7:0]    cmd_tag    [2];
    logic          data_valid [2];
    logic          data_ready [2];
    logic [DW-1:0] data       [2];
    logic          data_last  [2];
    logic          pcie_ready [2];
    logic [143:0]  headin     [2];
    logic          hwrreq     [2];
    logic [DW-1:0] datain     [2];
    logic          wrreq      [2];
    logic          busy       [2];
    logic          err        [2];
    logic [31:0]   seg_cnt    [2];
    logic [2:0]    dbg_state  [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pcie_wr_seg #(
            .BUFUNIT((g == 0) ? BU0 : BU1),
            .DWIDTH (DW),
            .LEN_W  (16)
        ) u_dut (
            .user_clk    (clk),
            .user_rst_n  (rst_n),
            .iCmd_valid  (cmd_valid[g]),
            .oCmd_ready  (cmd_ready[g]),
            .iCmd_addr   (cmd_addr[g]),
            .iCmd_len    (cmd_len[g]),
            .iCmd_tag    (cmd_tag[g]),
            .iData_valid (data_valid[g]),
            .oData_ready (data_ready[g]),
            .iData       (data[g]),
            .iData_last  (data_last[g]),
            .iPcie_ready (pcie_ready[g]),
            .oPcie_headin(headin[g]),
            .oPcie_Hwrreq(hwrreq[g]),
            .oPcie_datain(datain[g]),
            .oPcie_wrreq (wrreq[g]),
            .oBusy       (busy[g]),
            .oErr        (err[g]),
            .oSeg_cnt    (seg_cnt[g]),
            .oDbg_state  (dbg_state[g])
        );
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int failures = 0;

    logic [DW:0]   src_q     [2][$];   // {last, beat} waiting to be offered
    logic [DW-1:0] exp_wr_q  [2][$];
    logic [143:0]  exp_hd_q  [2][$];
    logic [DW-1:0] wr_q      [2][$];   // observed data strobes
    logic [143:0]  hd_q      [2][$];   // observed header strobes
    int            seg_exp   [2];
    logic          err_exp   [2];
    int            rdy_mode  [2];      // 0 low, 1 high, 2 random
    logic          gap_en;
    logic          acc       [2];
    int            last_wr_cyc [2];

    task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] b;
        for (int i = 0; i < DW / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // ---------------- data source and ready driver ----------------
    always @(posedge clk) begin
        #2;
        for (int g = 0; g < 2; g++) begin
            if (acc[g] && src_q[g].size() > 0) void'(src_q[g].pop_front());
            if (src_q[g].size() == 0) begin
                data_valid[g] = 1'b0;
                data_last[g]  = 1'b0;
            end else if (!data_valid[g] || acc[g]) begin
                if (!gap_en || $urandom_range(0, 3) != 0) begin
                    data_valid[g] = 1'b1;
                    {data_last[g], data[g]} = src_q[g][0];
                end else begin
                    data_valid[g] = 1'b0;
                end
            end
            case (rdy_mode[g])
                0:       pcie_ready[g] = 1'b0;
                1:       pcie_ready[g] = 1'b1;
                default: pcie_ready[g] = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // ---------------- monitor (samples on the falling edge) ----------------
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            acc[g] = data_valid[g] && data_ready[g];
            if (rst_n) begin
                if (wrreq[g]) begin
                    chk("strobe_exclusive", 256'(hwrreq[g]), 256'd0);
                    wr_q[g].push_back(datain[g]);
                    last_wr_cyc[g] = cyc;
                end
                if (hwrreq[g]) begin
                    hd_q[g].push_back(headin[g]);
                    chk("head_follows_last_beat", 256'(cyc - last_wr_cyc[g]), 256'd1);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Splits a command by the boundary rule and queues the expected headers,
    // data beats and source beats. bad_last >= 0 puts the last flag there.
    task automatic load_cmd(input int d, input logic [63:0] a, input logic [15:0] len,
                            input logic [7:0] tag, input int bad_last);
        int bu, rem, room, sl, nbeats;
        logic [63:0] ca;
        logic [DW-1:0] b;
        logic lst;
        bu = (d == 0) ? BU0 : BU1;
        nbeats = 0;
        if (a[4:0] != 5'd0 || len[1:0] != 2'b00) begin
            err_exp[d] = 1'b1;
            return;
        end
        ca = a;
        rem = int'(len);
        while (rem > 0) begin
            room = bu - int'(ca % 64'(bu));
            sl = (rem < room) ? rem : room;
            exp_hd_q[d].push_back({58'd0, (rem == sl), tag, 13'(sl), ca});
            nbeats += (sl + BB - 1) / BB;
            ca += 64'(sl);
            rem -= sl;
            seg_exp[d]++;
        end
        for (int i = 0; i < nbeats; i++) begin
            b = rand_beat();
            lst = (i == nbeats - 1);
            if (bad_last >= 0) begin
                lst = (i == bad_last);
                err_exp[d] = 1'b1;
            end
            src_q[d].push_back({lst, b});
            exp_wr_q[d].push_back(b);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input int d, input logic [63:0] a, input logic [15:0] len,
                            input logic [7:0] tag);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk);
            #1;
            if (cmd_ready[d]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("cmd_ready_timeout", 256'(ok), 256'd1);
        cmd_addr[d]  = a;
        cmd_len[d]   = len;
        cmd_tag[d]   = tag;
        cmd_valid[d] = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk);
            if (!busy[d] && cmd_ready[d]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_timeout", 256'(ok), 256'd1);
    endtask

    task automatic check_cmd(input int d);
        chk("hdr_count", 256'(hd_q[d].size()), 256'(exp_hd_q[d].size()));
        while (hd_q[d].size() > 0 && exp_hd_q[d].size() > 0)
            chk("hdr", 256'(hd_q[d].pop_front()), 256'(exp_hd_q[d].pop_front()));
        chk("beat_count", 256'(wr_q[d].size()), 256'(exp_wr_q[d].size()));
        while (wr_q[d].size() > 0 && exp_wr_q[d].size() > 0)
            chk("beat_data", wr_q[d].pop_front(), exp_wr_q[d].pop_front());
        hd_q[d].delete();
        wr_q[d].delete();
        exp_hd_q[d].delete();
        exp_wr_q[d].delete();
        chk("seg_cnt", 256'(seg_cnt[d]), 256'(seg_exp[d]));
        chk("err", 256'(err[d]), 256'(err_exp[d]));
    endtask

    task automatic run_cmd(input int d, input logic [63:0] a, input logic [15:0] len,
                           input logic [7:0] tag, input int bad_last);
        load_cmd(d, a, len, tag, bad_last);
        send_cmd(d, a, len, tag);
        wait_idle(d);
        check_cmd(d);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed and random sequence ----------------
    initial begin
        int n;
        bit seen;
        logic [63:0] ra;
        logic [15:0] rl;

        rst_n = 1'b0;
        gap_en = 1'b0;
        for (int g = 0; g < 2; g++) begin
            cmd_valid[g] = 1'b0;
            cmd_addr[g]  = '0;
            cmd_len[g]   = '0;
            cmd_tag[g]   = '0;
            data_valid[g] = 1'b0;
            data[g]      = '0;
            data_last[g] = 1'b0;
            pcie_ready[g] = 1'b0;
            rdy_mode[g]  = 1;
            seg_exp[g]   = 0;
            err_exp[g]   = 1'b0;
            acc[g]       = 1'b0;
            last_wr_cyc[g] = 0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            chk("rst_cmd_ready", 256'(cmd_ready[g]), 256'd0);
            chk("rst_data_ready", 256'(data_ready[g]), 256'd0);
            chk("rst_wrreq", 256'(wrreq[g]), 256'd0);
            chk("rst_hwrreq", 256'(hwrreq[g]), 256'd0);
            chk("rst_headin", 256'(headin[g]), 256'd0);
            chk("rst_datain", datain[g], 256'd0);
            chk("rst_busy", 256'(busy[g]), 256'd0);
            chk("rst_err", 256'(err[g]), 256'd0);
            chk("rst_seg_cnt", 256'(seg_cnt[g]), 256'd0);
            chk("rst_state", 256'(dbg_state[g]), 256'(IDLE));
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("cmd_ready_after_rst", 256'(cmd_ready[0]), 256'd1);

        // Single in-boundary segment, with acceptance-to-first-strobe latency
        load_cmd(0, 64'h1000, 16'd256, 8'h5A, -1);
        send_cmd(0, 64'h1000, 16'd256, 8'h5A);
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n++;
            if (wrreq[0]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("first_wrreq_seen", 256'(seen), 256'd1);
        chk("first_wrreq_latency", 256'(n), 256'd3);
        wait_idle(0);
        check_cmd(0);

        // Command straddling a 4 KiB boundary
        run_cmd(0, 64'h0F80, 16'h0200, 8'h11, -1);

        // 256-byte segments: 256/256/256/232
        run_cmd(1, 64'h0, 16'd1000, 8'h22, -1);

        // Segment credit withheld in WAIT
        rdy_mode[0] = 0;
        load_cmd(0, 64'h3000, 16'd256, 8'h33, -1);
        send_cmd(0, 64'h3000, 16'd256, 8'h33);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stall_data_ready", 256'(data_ready[0]), 256'd0);
            chk("stall_wrreq", 256'(wrreq[0]), 256'd0);
        end
        chk("stall_state", 256'(dbg_state[0]), 256'(WAIT));
        chk("stall_busy", 256'(busy[0]), 256'd1);
        @(posedge clk);
        #1;
        rdy_mode[0] = 1;
        @(negedge clk);
        chk("release_wrreq_c0", 256'(wrreq[0]), 256'd0);
        @(negedge clk);
        chk("release_wrreq_c1", 256'(wrreq[0]), 256'd1);
        wait_idle(0);
        check_cmd(0);

        // Misaligned address: dropped, error raised
        run_cmd(0, 64'h1004, 16'd256, 8'h44, -1);
        chk("misaligned_busy", 256'(busy[0]), 256'd0);

        // Zero length: dropped silently
        run_cmd(1, 64'h100, 16'd0, 8'h55, -1);

        // Early last flag: error, but all beats and the header are written
        run_cmd(1, 64'h200, 16'd256, 8'h66, 2);

        // Length not a multiple of 4
        run_cmd(1, 64'h400, 16'd6, 8'h77, -1);

        // Reset in the middle of a segment
        load_cmd(1, 64'h300, 16'd256, 8'h88, -1);
        send_cmd(1, 64'h300, 16'd256, 8'h88);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wr_q[1].size() == 4) begin
                seen = 1'b1;
                break;
            end
        end
        chk("four_beats_seen", 256'(seen), 256'd1);
        @(posedge clk);
        #3;
        chk("pre_rst_wrreq", 256'(wrreq[1]), 256'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_wrreq", 256'(wrreq[1]), 256'd0);
        chk("midrst_data_ready", 256'(data_ready[1]), 256'd0);
        chk("midrst_busy", 256'(busy[1]), 256'd0);
        chk("midrst_datain", datain[1], 256'd0);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            src_q[g].delete();
            wr_q[g].delete();
            hd_q[g].delete();
            exp_wr_q[g].delete();
            exp_hd_q[g].delete();
            seg_exp[g] = 0;
            err_exp[g] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_seg_cnt", 256'(seg_cnt[1]), 256'd0);
        chk("postrst_err", 256'(err[1]), 256'd0);
        run_cmd(1, 64'h300, 16'd256, 8'h99, -1);

        // Address wrap at 2^64
        run_cmd(0, 64'hFFFF_FFFF_FFFF_FF00, 16'h0200, 8'hA5, -1);

        // Randomized commands with data gaps and random segment credit
        gap_en = 1'b1;
        rdy_mode[0] = 2;
        rdy_mode[1] = 2;
        for (int i = 0; i < 16; i++) begin
            ra = {$urandom, $urandom};
            ra[4:0] = 5'd0;
            rl = 16'($urandom_range(0, 1500) * 4);
            run_cmd(i % 2, ra, rl, 8'($urandom), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
